pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer.
- Sits directly downstream of the PC+4 adder and consumes its result.
- Selects the next PC from sequential PC+4 or a branch/jump redirect.
- Issues one instruction-memory request at a time and delivers (pc, inst) pairs to decode over a valid/ready handshake. Stale responses after a redirect are discarded.

Parameters:
- RESET_PC, 32'h0000_2000, PC value loaded on reset; first fetch address.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- redirect_valid  input  1  branch/jump taken; overrides sequential PC
- redirect_pc  input  32  redirect target
- pc_plus4  input  32  PC+4 from adder (adder input driven by pc_cur)
- pc_cur  output  32  current PC register value
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request this cycle
- imem_req_addr  output  32  fetch address (= pc_cur)
- imem_resp_valid  input  1  instruction word returned (cannot be backpressured)
- imem_resp_data  input  32  instruction word
- if_valid  output  1  fetched instruction available to decode
- if_ready  input  1  decode accepts this cycle
- if_pc  output  32  PC of delivered instruction
- if_inst  output  32  delivered instruction

Behaviour:
- Reset (rst=1 at edge):
  - pc_cur=RESET_PC; state=ISSUE; drop=0.
  - if_valid=0; if_pc=0; if_inst=0.
  - imem_req_valid forced 0 while rst=1.
- States:
  - ISSUE: imem_req_valid=1 only when the output buffer is free, i.e. if_valid=0 or (if_valid & if_ready) this cycle. Request accepted (valid & ready) -> WAIT.
  - WAIT: imem_req_valid=0. On imem_resp_valid:
    - drop=1 -> discard the word, clear drop, go to ISSUE; pc unchanged because it already holds the redirect target.
    - drop=0 -> if_valid<=1, if_pc<=pc_cur, if_inst<=imem_resp_data, pc_cur<=pc_plus4, go to ISSUE.
- At most one outstanding request. Because requests issue only when the buffer is free, every response has space.
- Output buffer holds if_valid/if_pc/if_inst stable until if_ready=1. A handshake with no new fill clears if_valid.
- Redirect has highest priority, any state, same-cycle effects:
  - pc_cur<=redirect_pc; if_valid<=0, flushing a buffered instruction even if if_ready=1.
  - Request outstanding, or accepted this same cycle -> drop<=1, state=WAIT.
  - In ISSUE with no accept -> stay in ISSUE; the next request uses the new address.
  - Redirect in the same cycle as a non-dropped response -> the response is discarded, pc_cur takes redirect_pc, drop stays 0, state=ISSUE.
  - Redirect while drop=1 and a response arrives -> response discarded, drop stays 1 only if a newly accepted request is outstanding; otherwise drop=0.
- Latency: memory accept at edge N, response at N+k -> if_valid at N+k+1. Next request no earlier than cycle N+k+1.
- PC arithmetic is 32-bit wraparound (32'hFFFF_FFFC + 4 = 0), performed in the upstream adder.
- Reset mid-WAIT: state returns to ISSUE with drop=0. The memory is reset by the same rst, so no stale response arrives.

Optional Feature:
- Macro FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds output fetch_misaligned (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=0 sets fetch_misaligned=1, loads pc_cur with the raw target and enters HALT state (no requests, if_valid=0).
  - Only a redirect with aligned redirect_pc leaves HALT: fetch_misaligned<=0, state ISSUE.
- Undefined: redirect_pc[1:0] are forced to 2'b00 when loaded; no extra port or state.

Test Plan:
- Reset release, memory always ready, 1-cycle response, if_ready=1 -> first imem_req_addr=0x2000; delivered if_pc sequence 0x2000, 0x2004, 0x2008 with matching if_inst.
- if_ready=0 for 5 cycles after first delivery -> if_valid, if_pc=0x2000 and if_inst held stable; no new request issued until the cycle if_ready=1.
- Redirect to 0x3000 while WAITing on 0x2004 (response 3 cycles later) -> that response discarded; next delivered if_pc=0x3000.
- Redirect to 0x4000 in the same cycle as the 0x2008 response -> 0x2008 never delivered; next request addr=0x4000.
- pc at 0xFFFF_FFFC -> delivered 0xFFFF_FFFC, then next request addr=0x0000_0000.
- With FETCH_MISALIGN_TRAP_EN, redirect to 0x3002 -> fetch_misaligned=1, no requests. Then redirect to 0x3004 -> fetch_misaligned=0, delivery resumes at 0x3004. Without the macro, redirect to 0x3002 -> fetch address 0x3000.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register and single-outstanding instruction fetch sequencer (option: FETCH_MISALIGN_TRAP_EN)
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_2000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic [31:0] pc_plus4,
   output logic [31:0] pc_cur,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic        fetch_misaligned
`endif
);

   localparam logic [1:0] ST_ISSUE = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
`ifdef FETCH_MISALIGN_TRAP_EN
   localparam logic [1:0] ST_HALT  = 2'd2;
`endif

   logic [1:0]  state;
   logic        drop;
   logic        buf_free;
   logic        req_fire;
   logic        in_flight;
   logic [31:0] redirect_target;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        redirect_bad;
`endif

   assign imem_req_addr = pc_cur;

   // Request gating, and whether a request will still be in flight after this edge
   always_comb begin
      buf_free       = !if_valid || if_ready;
      imem_req_valid = !rst && (state == ST_ISSUE) && buf_free;
      req_fire       = imem_req_valid && imem_req_ready;
      in_flight      = req_fire || ((state == ST_WAIT) && !imem_resp_valid);
`ifdef FETCH_MISALIGN_TRAP_EN
      // A dropped request can still be outstanding while halted
      in_flight      = in_flight || ((state == ST_HALT) && drop && !imem_resp_valid);
      redirect_bad   = (redirect_pc[1:0] != 2'b00);
      redirect_target = redirect_pc;
`else
      redirect_target = redirect_pc & 32'hFFFF_FFFC;
`endif
   end

   // PC, sequencer state, stale-response drop flag and decode output buffer
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_cur   <= RESET_PC;
         state    <= ST_ISSUE;
         drop     <= 1'b0;
         if_valid <= 1'b0;
         if_pc    <= 32'd0;
         if_inst  <= 32'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
         fetch_misaligned <= 1'b0;
`endif
      end else if (redirect_valid) begin
         // Redirect wins: flush the buffer and mark any in-flight word as stale
         pc_cur   <= redirect_target;
         if_valid <= 1'b0;
         drop     <= in_flight;
`ifdef FETCH_MISALIGN_TRAP_EN
         if (redirect_bad) begin
            state            <= ST_HALT;
            fetch_misaligned <= 1'b1;
         end else begin
            state            <= in_flight ? ST_WAIT : ST_ISSUE;
            fetch_misaligned <= 1'b0;
         end
`else
         state    <= in_flight ? ST_WAIT : ST_ISSUE;
`endif
      end else begin
         if (if_valid && if_ready)
            if_valid <= 1'b0;
         case (state)
            ST_ISSUE: begin
               if (req_fire)
                  state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (imem_resp_valid) begin
                  state <= ST_ISSUE;
                  if (drop) begin
                     drop <= 1'b0;
                  end else begin
                     if_valid <= 1'b1;
                     if_pc    <= pc_cur;
                     if_inst  <= imem_resp_data;
                     pc_cur   <= pc_plus4;
                  end
               end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            ST_HALT: begin
               if (imem_resp_valid)
                  drop <= 1'b0;
            end
`endif
            default: state <= ST_ISSUE;
         endcase
      end
   end

endmodule
